// File: rtl/branch_resolver.sv
// Carries prediction/index through F->D->E, resolves branches in E, drives one-hot predictor update and GHR.
// Optional saturating branch/mispredict counters under `BRU_PERF_CNT_EN; outputs are tied to 0 otherwise.
module branch_resolver #(
  parameter int IDX_WIDTH = 4,
  parameter int GHR_WIDTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [31:0]                   pc_f_i,
  input  logic                          pc_src_pred_f_i,
  input  logic                          stall_d_i,
  input  logic                          flush_d_i,
  input  logic                          stall_e_i,
  input  logic                          flush_e_i,
  input  logic                          branch_op_e_i,
  input  logic                          pc_src_res_e_i,
  output logic [(2**IDX_WIDTH)-1:0]     update_en_o,
  output logic                          pc_src_res_o,
  output logic                          mispredict_e_o,
  output logic [1:0]                    recover_sel_o,
  output logic [GHR_WIDTH-1:0]          ghr_o,
  output logic [CNT_WIDTH-1:0]          branch_cnt_o,
  output logic [CNT_WIDTH-1:0]          mispredict_cnt_o
);
  localparam int NUM_ENTRIES = 2**IDX_WIDTH;

  logic                 fd_vld_q, fd_vld_d;
  logic [IDX_WIDTH-1:0] fd_idx_q, fd_idx_d;
  logic                 fd_pred_q, fd_pred_d;
  logic                 ex_vld_q, ex_vld_d;
  logic [IDX_WIDTH-1:0] ex_idx_q, ex_idx_d;
  logic                 ex_pred_q, ex_pred_d;
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic                 resolve, retire;
  logic                 unused_pc;

  assign unused_pc = ^{pc_f_i[31:IDX_WIDTH+2], pc_f_i[1:0]};

  always_comb begin
    fd_vld_d  = fd_vld_q;
    fd_idx_d  = fd_idx_q;
    fd_pred_d = fd_pred_q;
    if (flush_d_i) begin
      fd_vld_d = 1'b0;
    end else if (!stall_d_i) begin
      fd_vld_d  = 1'b1;
      fd_idx_d  = pc_f_i[IDX_WIDTH+1:2];
      fd_pred_d = pc_src_pred_f_i;
    end
  end

  always_comb begin
    ex_vld_d  = ex_vld_q;
    ex_idx_d  = ex_idx_q;
    ex_pred_d = ex_pred_q;
    if (flush_e_i) begin
      ex_vld_d = 1'b0;
    end else if (!stall_e_i) begin
      ex_vld_d  = fd_vld_q;
      ex_idx_d  = fd_idx_q;
      ex_pred_d = fd_pred_q;
    end
  end

  // A stalled branch only retires on its last E cycle; the reset cycle never retires.
  assign resolve        = ex_vld_q & branch_op_e_i;
  assign retire         = resolve & ~stall_e_i & ~reset_i;
  assign mispredict_e_o = resolve & (ex_pred_q != pc_src_res_e_i);
  assign recover_sel_o  = mispredict_e_o ? (pc_src_res_e_i ? 2'b01 : 2'b10) : 2'b00;
  assign pc_src_res_o   = pc_src_res_e_i;
  assign update_en_o    = retire ? ({{(NUM_ENTRIES-1){1'b0}}, 1'b1} << ex_idx_q)
                                 : {NUM_ENTRIES{1'b0}};

  assign ghr_d = retire ? {ghr_q[GHR_WIDTH-2:0], pc_src_res_e_i} : ghr_q;
  assign ghr_o = ghr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fd_vld_q  <= 1'b0;
      fd_idx_q  <= '0;
      fd_pred_q <= 1'b0;
      ex_vld_q  <= 1'b0;
      ex_idx_q  <= '0;
      ex_pred_q <= 1'b0;
      ghr_q     <= '0;
    end else begin
      fd_vld_q  <= fd_vld_d;
      fd_idx_q  <= fd_idx_d;
      fd_pred_q <= fd_pred_d;
      ex_vld_q  <= ex_vld_d;
      ex_idx_q  <= ex_idx_d;
      ex_pred_q <= ex_pred_d;
      ghr_q     <= ghr_d;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (retire && (br_cnt_q != {CNT_WIDTH{1'b1}})) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
    if (retire && mispredict_e_o && (mp_cnt_q != {CNT_WIDTH{1'b1}}))
      mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mp_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized and directed bench for branch_resolver against a stage-occupancy reference model.
module tb_branch_resolver;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset_i, pc_src_pred_f_i, stall_d_i, flush_d_i, stall_e_i, flush_e_i;
  logic        branch_op_e_i, pc_src_res_e_i;
  logic [31:0] pc_f_i;
  logic [15:0] update_en_o;
  logic        pc_src_res_o, mispredict_e_o;
  logic [1:0]  recover_sel_o;
  logic [7:0]  ghr_o;
  logic [CW-1:0] branch_cnt_o, mispredict_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: what each stage currently holds, plus architectural history/counters.
  typedef struct { bit v; int idx; bit pred; } slot_t;
  slot_t m_d, m_e;
  int    m_ghr, m_bc, m_mc;

  always #5 clk = ~clk;

  branch_resolver #(.IDX_WIDTH(4), .GHR_WIDTH(8), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .pc_f_i(pc_f_i), .pc_src_pred_f_i(pc_src_pred_f_i),
    .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .stall_e_i(stall_e_i), .flush_e_i(flush_e_i),
    .branch_op_e_i(branch_op_e_i), .pc_src_res_e_i(pc_src_res_e_i),
    .update_en_o(update_en_o), .pc_src_res_o(pc_src_res_o), .mispredict_e_o(mispredict_e_o),
    .recover_sel_o(recover_sel_o), .ghr_o(ghr_o), .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit pred, input bit bop, input bit res,
                       input bit sd, input bit fd, input bit se, input bit fe, input bit rst);
    pc_f_i = pc; pc_src_pred_f_i = pred; branch_op_e_i = bop; pc_src_res_e_i = res;
    stall_d_i = sd; flush_d_i = fd; stall_e_i = se; flush_e_i = fe; reset_i = rst;
  endtask

  function automatic int expected_cnt(input int c);
`ifdef BRU_PERF_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // Compare all outputs against the model for the current cycle, then advance one clock.
  task automatic cycle();
    bit res_now, mis, ret;
    int upd, rec;
    #1;
    res_now = m_e.v && branch_op_e_i;
    mis     = res_now && (m_e.pred != pc_src_res_e_i);
    ret     = res_now && !stall_e_i && !reset_i;
    upd     = ret ? (1 << m_e.idx) : 0;
    rec     = !mis ? 0 : (pc_src_res_e_i ? 1 : 2);
    chk("update_en", 32'(update_en_o), upd);
    chk("pc_src_res", 32'(pc_src_res_o), 32'(pc_src_res_e_i));
    if (!reset_i) begin
      chk("mispredict", 32'(mispredict_e_o), 32'(mis));
      chk("recover_sel", 32'(recover_sel_o), rec);
    end
    chk("ghr", 32'(ghr_o), m_ghr);
    chk("branch_cnt", 32'(branch_cnt_o), expected_cnt(m_bc));
    chk("mispredict_cnt", 32'(mispredict_cnt_o), expected_cnt(m_mc));
    @(posedge clk);
    if (reset_i) begin
      m_d = '{0, 0, 0}; m_e = '{0, 0, 0};
      m_ghr = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (ret) begin
        m_ghr = ((m_ghr << 1) | int'(pc_src_res_e_i)) & 8'hFF;
        if (m_bc < (1 << CW) - 1) m_bc++;
        if (mis && m_mc < (1 << CW) - 1) m_mc++;
      end
      if (flush_e_i) m_e.v = 0;
      else if (!stall_e_i) m_e = m_d;
      if (flush_d_i) m_d.v = 0;
      else if (!stall_d_i) m_d = '{1, int'(pc_f_i[5:2]), pc_src_pred_f_i};
    end
    #1;
  endtask

  task automatic filler(input bit bop, input bit res);
    drive(32'h100, 0, bop, res, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    m_d = '{0, 0, 0}; m_e = '{0, 0, 0}; m_ghr = 0; m_bc = 0; m_mc = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    cycle();

    // Reset state
    filler(1, 1); #1;
    chk("rst_update_en", 32'(update_en_o), 0);
    chk("rst_mispredict", 32'(mispredict_e_o), 0);
    chk("rst_recover", 32'(recover_sel_o), 0);
    chk("rst_ghr", 32'(ghr_o), 0);
    chk("rst_bcnt", 32'(branch_cnt_o), 0);

    // Correctly predicted taken branch at 0x14
    drive(32'h14, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    filler(0, 0); cycle();
    filler(1, 1); #1;
    chk("t1_update_en", 32'(update_en_o), 32'h20);
    chk("t1_mispredict", 32'(mispredict_e_o), 0);
    chk("t1_recover", 32'(recover_sel_o), 0);
    cycle();
    chk("t1_ghr", 32'(ghr_o), 32'h01);

    // Predicted taken, resolved not taken at 0x8
    drive(32'h8, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    filler(0, 0); cycle();
    filler(1, 0); #1;
    chk("t2_mispredict", 32'(mispredict_e_o), 1);
    chk("t2_recover", 32'(recover_sel_o), 2);
    chk("t2_update_en", 32'(update_en_o), 32'h4);
    cycle();
    chk("t2_mcnt", 32'(mispredict_cnt_o), expected_cnt(1));

    // Predicted not taken, resolved taken, then recovery flush
    drive(32'h30, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    filler(0, 0); cycle();
    filler(1, 1); #1;
    chk("t3_recover", 32'(recover_sel_o), 1);
    cycle();
    drive(32'h100, 0, 0, 0, 0, 1, 0, 1, 0); cycle();
    filler(1, 1); #1;
    chk("t3_flush_update", 32'(update_en_o), 0);
    chk("t3_flush_mis", 32'(mispredict_e_o), 0);
    cycle();
    chk("t3_ghr", 32'(ghr_o), 32'h05);

    // Branch stalled in E for three cycles retires exactly once
    drive(32'h3C, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    filler(0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 0, 1, 1, 1, 0, 1, 0, 0); #1;
      chk("t4_stall_update", 32'(update_en_o), 0);
      cycle();
    end
    filler(1, 1); #1;
    chk("t4_release_update", 32'(update_en_o), 32'h8000);
    cycle();
    chk("t4_ghr", 32'(ghr_o), 32'h0B);
    chk("t4_bcnt", 32'(branch_cnt_o), expected_cnt(4));
    chk("t4_mcnt", 32'(mispredict_cnt_o), expected_cnt(2));

    // Reset while a mispredicting branch sits in E
    drive(32'h20, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    filler(0, 0); cycle();
    drive(32'h100, 0, 1, 0, 0, 0, 0, 0, 1); cycle();
    filler(1, 0); #1;
    chk("t5_update_en", 32'(update_en_o), 0);
    chk("t5_mispredict", 32'(mispredict_e_o), 0);
    chk("t5_ghr", 32'(ghr_o), 0);
    chk("t5_bcnt", 32'(branch_cnt_o), 0);
    chk("t5_mcnt", 32'(mispredict_cnt_o), 0);
    cycle();

    // Random traffic without reset drives the narrow counters into saturation
    for (int i = 0; i < 600; i++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 0);
      cycle();
    end
    filler(0, 0); #1;
    chk("sat_bcnt", 32'(branch_cnt_o), expected_cnt((1 << CW) - 1));

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 49) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

- Execute-stage companion to the per-index 2-bit local predictors.
- Carries each fetched instruction's prediction and predictor index through the F→D→E pipeline registers.
- In execute, compares the carried prediction with the resolved branch outcome, and raises misprediction and recovery select.
- Drives exactly one predictor's update enable per retired branch, maintains a global history register, and optionally counts branches and mispredictions.

## Interface
Parameters:
- IDX_WIDTH, 4: predictor index bits, taken from pc_f_i[IDX_WIDTH+1:2]; NUM_ENTRIES = 2**IDX_WIDTH.
- GHR_WIDTH, 8: global history length, minimum 2.
- CNT_WIDTH, 32: performance counter width.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: reset. One clock; reset is synchronous and active-high.
- pc_f_i, input, 32: fetch-stage PC.
- pc_src_pred_f_i, input, 1: prediction selected from the predictor array for pc_f_i (1 = taken).
- stall_d_i, input, 1: hold the F→D register.
- flush_d_i, input, 1: invalidate the F→D register.
- stall_e_i, input, 1: hold the D→E register.
- flush_e_i, input, 1: invalidate the D→E register.
- branch_op_e_i, input, 1: the instruction in E is a conditional branch.
- pc_src_res_e_i, input, 1: resolved outcome of that branch (1 = taken).
- update_en_o, output, NUM_ENTRIES: one-hot enable to the local predictor array.
- pc_src_res_o, output, 1: pc_src_res_e_i forwarded to the predictor array.
- mispredict_e_o, output, 1: the E-stage prediction was wrong.
- recover_sel_o, output, 2: 00 = none, 01 = redirect to branch target, 10 = redirect to pc_e+4.
- ghr_o, output, GHR_WIDTH: global taken/not-taken history, newest outcome in bit 0.
- branch_cnt_o, output, CNT_WIDTH: retired conditional branches.
- mispredict_cnt_o, output, CNT_WIDTH: retired mispredictions.

## Operation
Pipeline registers:
- Each stage register holds {valid, idx[IDX_WIDTH-1:0], pred}.
- F→D register update priority:
  - reset_i: valid=0, idx=0, pred=0.
  - flush_d_i: valid=0.
  - stall_d_i: hold.
  - otherwise: load {1, pc_f_i[IDX_WIDTH+1:2], pc_src_pred_f_i}.
- D→E register uses the same priority with flush_e_i and stall_e_i, loading the F→D contents. Flush beats stall.

Resolution in E (combinational):
- resolve = valid_e & branch_op_e_i.
- mispredict_e_o = resolve & (pred_e != pc_src_res_e_i).
- recover_sel_o = 01 when mispredict and the actual outcome is taken; 10 when mispredict and the actual outcome is not taken; 00 otherwise. Code 11 is never driven.
- pc_src_res_o = pc_src_res_e_i.

Predictor update and retire:
- retire = resolve & ~stall_e_i. This ensures a stalled branch updates its predictor exactly once, on its final E cycle.
- update_en_o = one-hot(idx_e) when retire, else all zeros. Never more than one bit is set.

Global history:
- On retire, ghr <= {ghr[GHR_WIDTH-2:0], pc_src_res_e_i}; otherwise hold.

Recovery flush:
- This block does not flush the pipeline itself. The hazard unit consumes mispredict_e_o and asserts flush_d_i/flush_e_i.
- Non-branch instructions (branch_op_e_i=0) never update, never mispredict, and never shift the GHR.

## Timing
- Reset values: all valids 0, ghr_o=0, update_en_o=0, mispredict_e_o=0, recover_sel_o=00, both counters 0.
- Reset asserted mid-operation discards both in-flight entries on that edge; a branch in E during the reset cycle does not update history or counters.
- Prediction-to-E latency is 2 cycles absent stalls: sampled at edge N, resolvable in the cycle after edge N+1.
- mispredict_e_o, recover_sel_o and update_en_o are combinational in the E cycle. The predictor array, GHR and counters change on the following edge.
- A flush_e_i asserted in the same cycle as a resolving branch does not suppress that branch's update, because the flush only affects the next D→E load.
- With simultaneous stall_e_i and flush_e_i, the flush wins, and the E entry is invalid in the next cycle.

## Configuration
- BRU_PERF_CNT_EN defined:
  - On retire, branch_cnt_o increments.
  - On retire & mispredict, mispredict_cnt_o also increments.
  - Both counters saturate at all-ones and never wrap.
- BRU_PERF_CNT_EN undefined: no counter registers exist, and both outputs are tied to 0.

## Test plan
- Reset, then PC 0x0000_0014, pred=1, branch taken, no stalls → two cycles later update_en_o=0x0020, mispredict_e_o=0, recover_sel_o=00, ghr_o=0x01.
- PC 0x0000_0008, pred=1, resolved not-taken → mispredict_e_o=1, recover_sel_o=10, update_en_o=0x0004; with the macro on, mispredict_cnt_o=1.
- pred=0, resolved taken → recover_sel_o=01. Drive flush_d_i and flush_e_i the next cycle → the next E cycle has valid_e=0, update_en_o=0, ghr_o unchanged.
- Branch held in E for 3 cycles with stall_e_i=1 → update_en_o is zero for those 3 cycles, a single one-hot pulse follows on release, ghr_o shifts once, branch_cnt_o advances by 1.
- Preload branch_cnt_o to all-ones (CNT_WIDTH=4 build), retire one more branch → counter stays 4'hF.
- Assert reset_i while a mispredicting branch is in E → no update, ghr_o=0, counters 0 on the next cycle.
